// File: rtl/gb_lcd_capture.sv
// gb_lcd_capture
//   Captures the PPU's 2-bit pixel stream into a 160x144 frame buffer,
//   packing four pixels per byte (leftmost pixel in bits [7:6]).
//
//   Optional feature macro: GB_LCD_DOUBLE_BUFFER_EN
//     defined   : two banks (bank 1 at FB_BASE+5760); writes target the bank
//                 that is not FRAME_BANK, which toggles per completed frame.
//     undefined : single bank at FB_BASE, FRAME_BANK tied to 0.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   LCD_EN          : LCDC bit 7 (display enable)
//   PPU_MODE        : 0 H_BLANK, 1 V_BLANK, 2 SCAN, 3 DRAW
//   PX_OUT/PX_valid : pixel colour index and its qualifier
//   FB_WR/FB_ADDR/FB_DATA : registered frame buffer write port (no backpressure)
//   FRAME_DONE      : one-cycle pulse per completed frame
//   FRAME_BANK      : bank holding the most recently completed frame
//   FRAME_ERR       : sticky malformed line/frame flag (cleared by rst only)
module gb_lcd_capture #(
  parameter logic [13:0] FB_BASE = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        LCD_EN,
  input  logic [1:0]  PPU_MODE,
  input  logic [1:0]  PX_OUT,
  input  logic        PX_valid,
  output logic        FB_WR,
  output logic [13:0] FB_ADDR,
  output logic [7:0]  FB_DATA,
  output logic        FRAME_DONE,
  output logic        FRAME_BANK,
  output logic        FRAME_ERR
);

  typedef enum logic [1:0] {
    H_BLANK = 2'd0,
    V_BLANK = 2'd1,
    SCAN    = 2'd2,
    DRAW    = 2'd3
  } ppu_mode_e;

  typedef enum logic {SYNC, CAPTURE} state_e;

  state_e      state;
  ppu_mode_e   mode_q;
  logic        lcd_q;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [5:0]  pack;       // up to three earlier pixels of the current byte
  logic [12:0] addr;       // byte offset of the next write within the bank
  logic [12:0] line_base;  // y*40, kept as a running sum
  logic [13:0] bank_base;

`ifdef GB_LCD_DOUBLE_BUFFER_EN
  logic bank_q;
  assign FRAME_BANK = bank_q;
  assign bank_base  = bank_q ? FB_BASE : FB_BASE + 14'd5760;
`else
  assign FRAME_BANK = 1'b0;
  assign bank_base  = FB_BASE;
`endif

  logic       scan_start, line_end, vb_entry, lcd_fall;
  logic       px_take, px_drop, byte_done;
  logic [7:0] x_n;
  logic [5:0] pack_n;
  logic [7:0] pad_tmp, pad_data;

  always_comb begin
    scan_start = (mode_q == H_BLANK || mode_q == V_BLANK) && (PPU_MODE == SCAN);
    line_end   = (mode_q == DRAW) && (PPU_MODE == H_BLANK);
    vb_entry   = (mode_q != V_BLANK) && (PPU_MODE == V_BLANK);
    lcd_fall   = lcd_q && !LCD_EN;
    px_take    = PX_valid && (x < 8'd160) && (y < 8'd144);
    px_drop    = PX_valid && !((x < 8'd160) && (y < 8'd144));
    byte_done  = px_take && (x[1:0] == 2'd3);
    x_n        = x + {7'd0, px_take};
    pack_n     = px_take ? {pack[3:0], PX_OUT} : pack;
    // The x_n[1:0] valid pixels sit in the low bits of pack_n; left-align
    // them so the missing right-hand pixels read as colour 0.
    pad_tmp    = {2'b00, pack_n};
    pad_data   = pad_tmp << (4'd8 - {1'b0, x_n[1:0], 1'b0});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SYNC;
      mode_q     <= H_BLANK;
      lcd_q      <= 1'b0;
      x          <= '0;
      y          <= '0;
      pack       <= '0;
      addr       <= '0;
      line_base  <= '0;
      FB_WR      <= 1'b0;
      FB_ADDR    <= '0;
      FB_DATA    <= '0;
      FRAME_DONE <= 1'b0;
      FRAME_ERR  <= 1'b0;
`ifdef GB_LCD_DOUBLE_BUFFER_EN
      bank_q     <= 1'b0;
`endif
    end else begin
      mode_q     <= ppu_mode_e'(PPU_MODE);
      lcd_q      <= LCD_EN;
      FB_WR      <= 1'b0;
      FRAME_DONE <= 1'b0;
      if (lcd_fall) begin
        state     <= SYNC;
        x         <= '0;
        y         <= '0;
        pack      <= '0;
        addr      <= '0;
        line_base <= '0;
      end else begin
        case (state)
          SYNC: begin
            if (LCD_EN && scan_start) begin
              state     <= CAPTURE;
              x         <= '0;
              y         <= '0;
              pack      <= '0;
              addr      <= '0;
              line_base <= '0;
            end
          end
          CAPTURE: begin
            if (vb_entry) begin
              if (y != 8'd144) FRAME_ERR <= 1'b1;
              FRAME_DONE <= 1'b1;
`ifdef GB_LCD_DOUBLE_BUFFER_EN
              bank_q     <= ~bank_q;
`endif
              state      <= SYNC;
              x          <= '0;
              y          <= '0;
              pack       <= '0;
              addr       <= '0;
              line_base  <= '0;
            end else begin
              if (px_drop) FRAME_ERR <= 1'b1;
              if (byte_done) begin
                FB_WR   <= 1'b1;
                FB_ADDR <= bank_base + {1'b0, addr};
                FB_DATA <= {pack, PX_OUT};
              end
              if (line_end) begin
                // A same-cycle last pixel is folded in via x_n/pack_n; when it
                // completes a byte x_n[1:0] is 0, so no pad write competes.
                if (x_n[1:0] != 2'd0) begin
                  FB_WR   <= 1'b1;
                  FB_ADDR <= bank_base + {1'b0, addr};
                  FB_DATA <= pad_data;
                end
                if (x_n != 8'd160) FRAME_ERR <= 1'b1;
                // A complete line already leaves addr at the next line base,
                // so jumping there unconditionally is equivalent.
                if (y < 8'd144) begin
                  addr      <= line_base + 13'd40;
                  line_base <= line_base + 13'd40;
                  y         <= y + 8'd1;
                end
                x    <= '0;
                pack <= '0;
              end else begin
                x    <= x_n;
                pack <= pack_n;
                if (byte_done) addr <= addr + 13'd1;
              end
            end
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gb_lcd_capture.sv
// tb_gb_lcd_capture
//   Randomized stimulus with a line-level reference model; expected writes
//   and frame completions are queued and consumed by an independent monitor.
module tb_gb_lcd_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        LCD_EN;
  logic [1:0]  PPU_MODE;
  logic [1:0]  PX_OUT;
  logic        PX_valid;
  logic        FB_WR;
  logic [13:0] FB_ADDR;
  logic [7:0]  FB_DATA;
  logic        FRAME_DONE;
  logic        FRAME_BANK;
  logic        FRAME_ERR;

  int checks = 0;
  int errors = 0;

  logic [21:0] exp_wr[$];   // {addr, data}
  logic        exp_done[$]; // expected FRAME_BANK at FRAME_DONE

  int pix[200];
  int m_y   = 0;
  bit m_cap = 1'b0;
  bit m_err = 1'b0;
  bit m_bank = 1'b0;

  gb_lcd_capture #(.FB_BASE(14'd0)) dut (
    .clk(clk), .rst(rst), .LCD_EN(LCD_EN), .PPU_MODE(PPU_MODE),
    .PX_OUT(PX_OUT), .PX_valid(PX_valid), .FB_WR(FB_WR), .FB_ADDR(FB_ADDR),
    .FB_DATA(FB_DATA), .FRAME_DONE(FRAME_DONE), .FRAME_BANK(FRAME_BANK),
    .FRAME_ERR(FRAME_ERR)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic int bank_base();
`ifdef GB_LCD_DOUBLE_BUFFER_EN
    return m_bank ? 0 : 5760;
`else
    return 0;
`endif
  endfunction

  // Expected bytes of one captured line of n pixels held in pix[].
  function automatic void model_line(input int n);
    int k, nb, d;
    if (m_y >= 144) begin
      m_err = 1'b1;
      return;
    end
    k = (n < 160) ? n : 160;
    if (n > 160) m_err = 1'b1;
    nb = (k + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      d = 0;
      for (int j = 0; j < 4; j++)
        d = d * 4 + ((4 * b + j < k) ? pix[4 * b + j] : 0);
      exp_wr.push_back({14'(bank_base() + m_y * 40 + b), 8'(d)});
    end
    if (k != 160) m_err = 1'b1;
    m_y++;
  endfunction

  // pat: 0 random, 1 x mod 4, 2 all 3
  task automatic drive_line(input int n, input int pat, input bit same_edge, input bit gaps);
    for (int i = 0; i < n; i++)
      pix[i] = (pat == 0) ? int'($urandom_range(0, 3)) : (pat == 1) ? (i % 4) : 3;
    if (LCD_EN && !m_cap) begin
      m_cap = 1'b1;
      m_y   = 0;
    end
    if (m_cap) model_line(n);
    PPU_MODE = 2'd2;
    repeat (2) step();
    PPU_MODE = 2'd3;
    step();
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 15) == 0) begin
        PX_valid = 1'b0;
        step();
      end
      PX_valid = 1'b1;
      PX_OUT   = 2'(pix[i]);
      if (same_edge && i == n - 1) PPU_MODE = 2'd0;
      step();
    end
    PX_valid = 1'b0;
    PPU_MODE = 2'd0;
    repeat (2) step();
  endtask

  // Partial line then LCD off: only completed bytes are written.
  task automatic drive_partial(input int n);
    for (int i = 0; i < n; i++) pix[i] = int'($urandom_range(0, 3));
    if (m_cap) begin
      for (int b = 0; b < n / 4; b++)
        exp_wr.push_back({14'(bank_base() + m_y * 40 + b),
                          8'(pix[4*b] * 64 + pix[4*b+1] * 16 + pix[4*b+2] * 4 + pix[4*b+3])});
    end
    PPU_MODE = 2'd2;
    repeat (2) step();
    PPU_MODE = 2'd3;
    step();
    for (int i = 0; i < n; i++) begin
      PX_valid = 1'b1;
      PX_OUT   = 2'(pix[i]);
      step();
    end
    PX_valid = 1'b0;
    step();
    LCD_EN = 1'b0;
    m_cap  = 1'b0;
    m_y    = 0;
    repeat (3) step();
  endtask

  task automatic frame_end();
    PPU_MODE = 2'd1;
    if (m_cap) begin
      if (m_y != 144) m_err = 1'b1;
`ifdef GB_LCD_DOUBLE_BUFFER_EN
      m_bank = ~m_bank;
`endif
      exp_done.push_back(m_bank);
      m_cap = 1'b0;
    end
    repeat (4) step();
    chk("frame_bank", FRAME_BANK, m_bank);
    chk("frame_err", FRAME_ERR, m_err);
  endtask

  task automatic check_err(input string name);
    repeat (3) step();
    chk(name, FRAME_ERR, m_err);
  endtask

  // Monitor: consumes expectations whenever the DUT presents an event.
  always @(negedge clk) begin
    logic [21:0] e;
    logic        eb;
    if (rst === 1'b0) begin
      if (FB_WR === 1'b1) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data %0h expected no write", FB_ADDR, FB_DATA);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_addr", FB_ADDR, e[21:8]);
          chk("wr_data", FB_DATA, e[7:0]);
        end
      end
      if (FRAME_DONE === 1'b1) begin
        if (exp_done.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame_done: got pulse expected none");
        end else begin
          eb = exp_done.pop_front();
          chk("done_bank", FRAME_BANK, eb);
        end
      end
    end
  end

  initial begin
    rst      = 1'b1;
    LCD_EN   = 1'b0;
    PPU_MODE = 2'd1;
    PX_valid = 1'b0;
    PX_OUT   = 2'd0;
    repeat (3) step();
    chk("rst_fb_wr", FB_WR, 0);
    chk("rst_fb_addr", FB_ADDR, 0);
    chk("rst_fb_data", FB_DATA, 0);
    chk("rst_frame_done", FRAME_DONE, 0);
    chk("rst_frame_bank", FRAME_BANK, 0);
    chk("rst_frame_err", FRAME_ERR, 0);
    rst    = 1'b0;
    LCD_EN = 1'b1;
    step();

    // Pixels while still in SYNC are dropped silently.
    PPU_MODE = 2'd3;
    for (int i = 0; i < 12; i++) begin
      PX_valid = 1'b1;
      PX_OUT   = 2'($urandom_range(0, 3));
      step();
    end
    PX_valid = 1'b0;
    PPU_MODE = 2'd1;
    check_err("sync_px_err");

    // Frame 1: x mod 4 pattern, every byte 0x1B.
    for (int y = 0; y < 144; y++) drive_line(160, 1, 1'b0, 1'b0);
    frame_end();

    // Frame 2: LCD dropped at line 70 pixel 50.
    for (int y = 0; y < 70; y++) drive_line(160, 0, 1'b0, 1'b1);
    drive_partial(50);
    drive_line(20, 0, 1'b0, 1'b0);
    frame_end();
    LCD_EN = 1'b1;
    step();

    // Frame 3: random pixels with gaps, last pixel coincident with line end on y=10.
    for (int y = 0; y < 144; y++) drive_line(160, 0, (y == 10), 1'b1);
    frame_end();

    // Frame 4: malformed lines.
    for (int y = 0; y < 3; y++) drive_line(160, 0, 1'b0, 1'b1);
    check_err("err_before_161");
    drive_line(161, 0, 1'b0, 1'b0);
    check_err("err_after_161");
    drive_line(160, 0, 1'b0, 1'b0);
    drive_line(158, 2, 1'b0, 1'b0);
    for (int y = 6; y < 144; y++) drive_line(int'($urandom_range(0, 40)), 0, 1'b0, 1'b0);
    drive_line(20, 0, 1'b0, 1'b0);
    frame_end();

    chk("pending_writes", exp_wr.size(), 0);
    chk("pending_frame_done", exp_done.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gb_lcd_capture.md
# gb_lcd_capture

Pixel-capture stage directly downstream of the PPU. Consumes the PPU's 2-bit pixel stream (`PX_OUT`/`PX_valid`) and its mode output (`PPU_MODE`), tracks line and frame position, and packs four pixels per byte into a 160×144 frame buffer write port. The frame buffer is read by the display scanout logic.

## Interface
- `FB_BASE`, default 0: base byte address of bank 0 in the frame buffer.
- `clk` input, 1: system clock. Also the PPU clock.
- `rst` input, 1: synchronous, active-high reset.
- `LCD_EN` input, 1: LCDC bit 7. Low means the display is off.
- `PPU_MODE` input, 2: PPU mode. 0 = H_BLANK, 1 = V_BLANK, 2 = SCAN, 3 = DRAW.
- `PX_OUT` input, 2: pixel colour index.
- `PX_valid` input, 1: `PX_OUT` is valid this cycle.
- `FB_WR` output, 1: frame buffer write strobe. One-cycle pulse.
- `FB_ADDR` output, 14: frame buffer byte address.
- `FB_DATA` output, 8: packed pixels. The leftmost pixel is in bits [7:6].
- `FRAME_DONE` output, 1: one-cycle pulse when a frame completes.
- `FRAME_BANK` output, 1: bank holding the most recently completed frame.
- `FRAME_ERR` output, 1: sticky flag. Set on any malformed line or frame.

## Operation
- Reset: all outputs are 0, and state = SYNC.
- State SYNC:
  - All pixels are dropped.
  - Go to CAPTURE when `LCD_EN`=1 and `PPU_MODE` changes from V_BLANK or H_BLANK to SCAN, with line count y=0.
  - Coming out of reset or an LCD-off period, the first SCAN also counts as a frame start.
- State CAPTURE:
  - On each `PX_valid` with x<160:
    - Shift `PX_OUT` into the pack register; x increments.
    - On every 4th pixel, issue a write at `FB_ADDR` = bank base + y·40 + x/4.
  - The address is a running counter. No multiplier is used.
  - Pixels with x≥160 are dropped and set `FRAME_ERR`.
- Line end is the `PPU_MODE` change from DRAW to H_BLANK:
  - If x is not a multiple of 4, pad the partial byte with 0 pixels and write it.
  - If x≠160, set `FRAME_ERR` and move the address counter to (y+1)·40.
  - Then y increments and x is cleared.
- Frame end is `PPU_MODE` entering V_BLANK while in CAPTURE:
  - If y≠144, set `FRAME_ERR`.
  - Pulse `FRAME_DONE`, toggle the write bank, update `FRAME_BANK`, then go to SYNC.
- If y reaches 144 and another DRAW line follows, its pixels are dropped and `FRAME_ERR` is set. Writes never exceed address 5759 past the bank base.
- `LCD_EN` falling in any state:
  - Go to SYNC on the next cycle.
  - Discard the partial byte and clear x, y and the address counter.
  - No `FRAME_DONE`; `FRAME_BANK` is unchanged.
- `FRAME_ERR` clears only on `rst`.

## Timing
- `FB_WR`/`FB_ADDR`/`FB_DATA` are registered. The write appears 1 cycle after the `PX_valid` cycle of the 4th pixel, or 1 cycle after the DRAW→H_BLANK change for a pad write.
- Mode changes are detected against a 1-cycle registered copy of `PPU_MODE`.
- At most one write per cycle.
  - If the last pixel arrives in the same cycle as DRAW→H_BLANK, the pixel is processed first.
  - If that pixel completes a byte, no pad write is issued.
- `FRAME_DONE` fires 1 cycle after V_BLANK entry is detected. `FRAME_BANK` updates in the same cycle.
- No backpressure: the frame buffer must accept a write on every cycle `FB_WR`=1.
- Throughput: up to 1 pixel per cycle.

## Configuration
- `GB_LCD_DOUBLE_BUFFER_EN` defined:
  - Two banks. Bank 1 base = `FB_BASE`+5760.
  - Writes go to the bank that is not `FRAME_BANK`, and the bank toggles per completed frame.
- Undefined:
  - Single bank at `FB_BASE`. `FRAME_BANK` is tied to 0.
  - `FRAME_DONE` is still pulsed.

## Test plan
- Full frame of 144 lines, each SCAN→DRAW with 160 `PX_valid` pixels of value (x mod 4), then H_BLANK, then V_BLANK:
  - 5760 writes, all with `FB_DATA`=0x1B, addresses 0..5759 in order.
  - One `FRAME_DONE`; `FRAME_ERR`=0.
- Short line of 158 pixels, all value 3, on y=5:
  - Pad write at address 239 with data 0xF0.
  - The next line starts at address 240; `FRAME_ERR`=1.
- Last pixel of a line arriving in the same cycle as DRAW→H_BLANK:
  - Exactly one write for address y·40+39; no pad write.
- `LCD_EN` dropped at line 70, pixel 50, then re-enabled:
  - No `FRAME_DONE` and no further writes until the next SCAN.
  - The next frame writes from address 0.
- With `GB_LCD_DOUBLE_BUFFER_EN`, two full frames:
  - Frame 1 is written at 5760..11519 and `FRAME_BANK` becomes 1.
  - Frame 2 is written at 0..5759 and `FRAME_BANK` becomes 0.
- Pixels during SYNC and a 161st pixel in a line:
  - Both are dropped with no writes; `FRAME_ERR`=1 after the 161st.
